// File: rtl/cpu_mem_pkg.sv
// Shared load/store encodings, responder FSM states and the request legality rule
// used by both the lane aligner and the verification model.
package cpu_mem_pkg;

   localparam logic [2:0] LB_F3  = 3'b000;
   localparam logic [2:0] LH_F3  = 3'b001;
   localparam logic [2:0] LW_F3  = 3'b010;
   localparam logic [2:0] LBU_F3 = 3'b100;
   localparam logic [2:0] LHU_F3 = 3'b101;

   localparam logic [1:0] SB_SZ = 2'b00;
   localparam logic [1:0] SH_SZ = 2'b01;
   localparam logic [1:0] SW_SZ = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_e;

   // True for conflicting enables, unknown encodings and misaligned half/word accesses.
   function automatic logic mem_req_illegal(input logic [3:0] rd_cmd,
                                            input logic [2:0] wr_cmd,
                                            input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (rd_cmd[3] && wr_cmd[2]) begin
         bad = 1'b1;
      end else if (rd_cmd[3]) begin
         case (rd_cmd[2:0])
            LB_F3, LBU_F3: bad = 1'b0;
            LH_F3, LHU_F3: bad = addr_lo[0];
            LW_F3:         bad = |addr_lo;
            default:       bad = 1'b1;
         endcase
      end else if (wr_cmd[2]) begin
         case (wr_cmd[1:0])
            SB_SZ:   bad = 1'b0;
            SH_SZ:   bad = addr_lo[0];
            SW_SZ:   bad = |addr_lo;
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// CPU load/store bus between the pipeline (master) and the data memory responder (slave).
interface data_memory_responder_if;
   logic [3:0]  DATA_MEM_READ;
   logic [2:0]  DATA_MEM_WRITE;
   logic [31:0] ADDRESS;
   logic [31:0] WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT;
   logic        MEM_ERROR;

   modport master (
      output DATA_MEM_READ, DATA_MEM_WRITE, ADDRESS, WRITE_DATA,
      input  READ_DATA, BUSYWAIT, MEM_ERROR
   );

   modport slave (
      input  DATA_MEM_READ, DATA_MEM_WRITE, ADDRESS, WRITE_DATA,
      output READ_DATA, BUSYWAIT, MEM_ERROR
   );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and replicated write word,
// load lane selection with sign/zero extension, and the illegal-request flag.
module mem_lane_align
   import cpu_mem_pkg::*;
(
   input  logic [3:0]  rd_cmd_i,
   input  logic [2:0]  wr_cmd_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wword_o,
   output logic [31:0] load_o,
   output logic        illegal_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel  = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign half_sel  = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
   assign illegal_o = mem_req_illegal(rd_cmd_i, wr_cmd_i, addr_lo_i);

   // Store data is replicated across lanes; the byte-enable picks which lanes land.
   always_comb begin
      byte_en_o = 4'b0000;
      wword_o   = 32'h0;
      if (wr_cmd_i[2]) begin
         case (wr_cmd_i[1:0])
            SB_SZ: begin
               byte_en_o = 4'b0001 << addr_lo_i;
               wword_o   = {4{wdata_i[7:0]}};
            end
            SH_SZ: begin
               byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
               wword_o   = {2{wdata_i[15:0]}};
            end
            SW_SZ: begin
               byte_en_o = 4'b1111;
               wword_o   = wdata_i;
            end
            default: begin
               byte_en_o = 4'b0000;
               wword_o   = 32'h0;
            end
         endcase
      end
   end

   always_comb begin
      load_o = 32'h0;
      case (rd_cmd_i[2:0])
         LB_F3:   load_o = {{24{byte_sel[7]}}, byte_sel};
         LH_F3:   load_o = {{16{half_sel[15]}}, half_sel};
         LW_F3:   load_o = rword_i;
         LBU_F3:  load_o = {24'h0, byte_sel};
         LHU_F3:  load_o = {16'h0, half_sel};
         default: load_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: IDLE/ACCESS/DONE handshake FSM with programmable latency
// over a word-wide array with byte-lane writes.
module data_memory_responder
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 4
)
(
   input  logic                   CLK,
   input  logic                   RESET,
   data_memory_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [31:0]     read_data_q, read_data_d;

   logic            req, rd_en, wr_en, illegal, access, busy, mem_we;
   logic [AW-1:0]   word_idx;
   logic [31:0]     rword, wword, load_val, merged_word;
   logic [3:0]      byte_en;
   logic [31:0]     mem_q [DEPTH_WORDS];
   logic            unused_addr;

   assign rd_en       = bus.DATA_MEM_READ[3];
   assign wr_en       = bus.DATA_MEM_WRITE[2];
   assign req         = rd_en | wr_en;
   assign word_idx    = bus.ADDRESS[AW+1:2];
   assign unused_addr = ^bus.ADDRESS[31:AW+2];
   assign rword       = mem_q[word_idx];

   mem_lane_align u_align (
      .rd_cmd_i  (bus.DATA_MEM_READ),
      .wr_cmd_i  (bus.DATA_MEM_WRITE),
      .addr_lo_i (bus.ADDRESS[1:0]),
      .wdata_i   (bus.WRITE_DATA),
      .rword_i   (rword),
      .byte_en_o (byte_en),
      .wword_o   (wword),
      .load_o    (load_val),
      .illegal_o (illegal)
   );

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = byte_en[gi] ? wword[8*gi +: 8] : rword[8*gi +: 8];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      read_data_d = read_data_q;
      busy        = 1'b0;
      access      = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by reset so the stall drops while reset is held with a request present.
            busy = req & RESET;
            if (req) begin
               if (illegal) begin
                  state_d     = DONE;
                  err_d       = 1'b1;
                  read_data_d = 32'h0;
               end else if (LATENCY == 1) begin
                  access  = 1'b1;
                  state_d = DONE;
                  err_d   = 1'b0;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = ACCESS;
                  err_d   = 1'b0;
               end
            end
         end
         ACCESS: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
      endcase
      if (access && rd_en) begin
         read_data_d = load_val;
      end
   end

   assign mem_we = access & wr_en & RESET;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         read_data_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         read_data_q <= read_data_d;
      end
   end

   // Array contents survive reset; writes are qualified by RESET so an aborted store never lands.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[word_idx] <= merged_word;
      end
   end

   assign bus.BUSYWAIT  = busy;
   assign bus.MEM_ERROR = (state_q == DONE) && err_q;
   assign bus.READ_DATA = read_data_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: driver queues expected outcomes,
// monitor checks stall length, error pulse and load data at each DONE cycle.
module tb_data_memory_responder;

   localparam logic [3:0] RD_NONE = 4'b0000;
   localparam logic [3:0] RD_LB   = 4'b1000;
   localparam logic [3:0] RD_LH   = 4'b1001;
   localparam logic [3:0] RD_LW   = 4'b1010;
   localparam logic [3:0] RD_LBU  = 4'b1100;
   localparam logic [3:0] RD_LHU  = 4'b1101;
   localparam logic [2:0] WR_NONE = 3'b000;
   localparam logic [2:0] WR_SB   = 3'b100;
   localparam logic [2:0] WR_SH   = 3'b101;
   localparam logic [2:0] WR_SW   = 3'b110;

   typedef struct {
      string       name;
      int          busy;
      logic        err;
      logic [31:0] rd;
   } exp_t;

   logic clk;
   logic rst_n;
   logic sel;
   int   n_total;
   int   n_pass;
   exp_t sb_q[$];

   data_memory_responder_if bus_a();
   data_memory_responder_if bus_b();

   data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut_a (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus_a)
   );

   data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus_b)
   );

   logic        mon_busy, mon_err;
   logic [31:0] mon_rd;
   assign mon_busy = sel ? bus_b.BUSYWAIT  : bus_a.BUSYWAIT;
   assign mon_err  = sel ? bus_b.MEM_ERROR : bus_a.MEM_ERROR;
   assign mon_rd   = sel ? bus_b.READ_DATA : bus_a.READ_DATA;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (sel) begin
         bus_b.DATA_MEM_READ = rd; bus_b.DATA_MEM_WRITE = wr;
         bus_b.ADDRESS = addr;     bus_b.WRITE_DATA = wd;
      end else begin
         bus_a.DATA_MEM_READ = rd; bus_a.DATA_MEM_WRITE = wr;
         bus_a.ADDRESS = addr;     bus_a.WRITE_DATA = wd;
      end
   endtask

   // Issues one request at posedge+1, waits for the DONE cycle, then lets the CPU advance.
   task automatic do_req(input string nm, input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_busy, input logic exp_err, input logic [31:0] exp_rd);
      exp_t e;
      bit   seen;
      bit   done;
      e.name = nm; e.busy = exp_busy; e.err = exp_err; e.rd = exp_rd;
      sb_q.push_back(e);
      drive(rd, wr, addr, wd);
      seen = 0;
      done = 0;
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         @(negedge clk);
         if (mon_busy) seen = 1;
         else if (seen) done = 1;
      end
      if (!done) begin
         n_total++;
         $display("FAIL timeout_%s: busywait never completed within 30 cycles", nm);
      end
      @(posedge clk);
      #1;
      drive(RD_NONE, WR_NONE, 32'h0, 32'h0);
   endtask

   // Monitor: counts stall cycles, checks the DONE cycle against the queued expectation.
   initial begin
      int  bc;
      bit  err_early;
      exp_t e;
      bc = 0;
      err_early = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bc = 0;
            err_early = 0;
         end else if (mon_busy) begin
            bc++;
            if (mon_err) err_early = 1;
         end else if (bc > 0) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_txn: completion with busy=%0d and no queued expectation", bc);
            end else begin
               e = sb_q.pop_front();
               $display("txn %s busy=%0d err=%0b rd=0x%08h", e.name, bc, mon_err, mon_rd);
               check({e.name, "_busy"}, 32'(bc), 32'(e.busy));
               check({e.name, "_err"}, {31'h0, mon_err | err_early}, {31'h0, e.err});
               check({e.name, "_rd"}, mon_rd, e.rd);
            end
            bc = 0;
            err_early = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0;
      n_pass  = 0;
      sel     = 1'b0;
      rst_n   = 1'b0;
      drive(RD_NONE, WR_NONE, 32'h0, 32'h0);
      sel = 1'b1;
      drive(RD_NONE, WR_NONE, 32'h0, 32'h0);
      sel = 1'b0;
      #12;
      check("rst_a_busy", {31'h0, bus_a.BUSYWAIT},  32'h0);
      check("rst_a_err",  {31'h0, bus_a.MEM_ERROR}, 32'h0);
      check("rst_a_rd",   bus_a.READ_DATA,          32'h0);
      check("rst_b_busy", {31'h0, bus_b.BUSYWAIT},  32'h0);
      check("rst_b_rd",   bus_b.READ_DATA,          32'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Word store/load with LATENCY=4
      do_req("t1_sw",  RD_NONE, WR_SW, 32'h10, 32'hDEADBEEF, 4, 1'b0, 32'h0);
      do_req("t1_lw",  RD_LW,  WR_NONE, 32'h10, 32'h0,       4, 1'b0, 32'hDEADBEEF);
      // Byte store into a known word, signed/unsigned byte loads
      do_req("t2_init", RD_NONE, WR_SW, 32'h20, 32'hAABBCCDD, 4, 1'b0, 32'hDEADBEEF);
      do_req("t2_sb",  RD_NONE, WR_SB, 32'h21, 32'h12345680, 4, 1'b0, 32'hDEADBEEF);
      do_req("t2_lb",  RD_LB,  WR_NONE, 32'h21, 32'h0,       4, 1'b0, 32'hFFFFFF80);
      do_req("t2_lbu", RD_LBU, WR_NONE, 32'h21, 32'h0,       4, 1'b0, 32'h00000080);
      do_req("t2_lw",  RD_LW,  WR_NONE, 32'h20, 32'h0,       4, 1'b0, 32'hAABB80DD);
      // Upper-half store, signed/unsigned half loads
      do_req("t3_init", RD_NONE, WR_SW, 32'h30, 32'h01020304, 4, 1'b0, 32'hAABB80DD);
      do_req("t3_sh",  RD_NONE, WR_SH, 32'h32, 32'hFFFF8001, 4, 1'b0, 32'hAABB80DD);
      do_req("t3_lh",  RD_LH,  WR_NONE, 32'h32, 32'h0,       4, 1'b0, 32'hFFFF8001);
      do_req("t3_lhu", RD_LHU, WR_NONE, 32'h32, 32'h0,       4, 1'b0, 32'h00008001);
      do_req("t3_lw",  RD_LW,  WR_NONE, 32'h30, 32'h0,       4, 1'b0, 32'h80010304);
      // Illegal requests: one-cycle stall, error pulse, READ_DATA cleared, array untouched
      do_req("t4_lw_mis", RD_LW, WR_NONE, 32'h13, 32'h0,     1, 1'b1, 32'h0);
      do_req("t4_lw10",   RD_LW, WR_NONE, 32'h10, 32'h0,     4, 1'b0, 32'hDEADBEEF);
      do_req("t4_sh_mis", RD_NONE, WR_SH, 32'h11, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
      do_req("t4_lw10b",  RD_LW, WR_NONE, 32'h10, 32'h0,     4, 1'b0, 32'hDEADBEEF);
      do_req("t4_bad_f3", 4'b1011, WR_NONE, 32'h30, 32'h0,   1, 1'b1, 32'h0);
      do_req("t4_lw30",   RD_LW, WR_NONE, 32'h30, 32'h0,     4, 1'b0, 32'h80010304);
      do_req("t4_both",   RD_LW, WR_SW,   32'h30, 32'h0,     1, 1'b1, 32'h0);
      do_req("t4_bad_sz", RD_NONE, 3'b111, 32'h30, 32'h0,    1, 1'b1, 32'h0);
      do_req("t4_lw30b",  RD_LW, WR_NONE, 32'h30, 32'h0,     4, 1'b0, 32'h80010304);
      // Reset during ACCESS discards the pending store
      do_req("t5_init", RD_NONE, WR_SW, 32'h40, 32'hA5A5A5A5, 4, 1'b0, 32'h80010304);
      do_req("t5_lw",   RD_LW, WR_NONE, 32'h40, 32'h0,      4, 1'b0, 32'hA5A5A5A5);
      drive(RD_NONE, WR_SW, 32'h40, 32'h12345678);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_abort_busy", {31'h0, bus_a.BUSYWAIT}, 32'h0);
      check("t5_abort_rd",   bus_a.READ_DATA,         32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      check("t5_held_busy",  {31'h0, bus_a.BUSYWAIT}, 32'h0);
      check("t5_held_err",   {31'h0, bus_a.MEM_ERROR}, 32'h0);
      drive(RD_NONE, WR_NONE, 32'h0, 32'h0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      do_req("t5_lw_after", RD_LW, WR_NONE, 32'h40, 32'h0, 4, 1'b0, 32'hA5A5A5A5);
      // LATENCY=1 instance: back-to-back accesses and address aliasing
      @(posedge clk); #1;
      sel = 1'b1;
      do_req("t6_sw_alias", RD_NONE, WR_SW, 32'h400, 32'h11223344, 1, 1'b0, 32'h0);
      do_req("t6_lw0",      RD_LW, WR_NONE, 32'h0,   32'h0,       1, 1'b0, 32'h11223344);
      do_req("t6_sw4",      RD_NONE, WR_SW, 32'h4,   32'h55667788, 1, 1'b0, 32'h11223344);
      do_req("t6_lw404",    RD_LW, WR_NONE, 32'h404, 32'h0,       1, 1'b0, 32'h55667788);
      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
